// File: rtl/macro_pkg.sv
// Shared opcode encoding and default sizing for the pipelined ALU.
package macro_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDC  = 4'd1,
    OP_SUB   = 4'd2,
    OP_SUBB  = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_ROL   = 4'd10,
    OP_ROR   = 4'd11,
    OP_INC   = 4'd12,
    OP_DEC   = 4'd13,
    OP_PASSA = 4'd14,
    OP_PASSB = 4'd15
  } opcode_e;

endpackage

// File: rtl/alu_pipe_param_if.sv
// Request/response bundle of the pipelined ALU; slave is the ALU side.
interface alu_pipe_param_if
  import macro_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  opcode_e          ctl;
  logic             valid_out;
  logic             ready_out;
  logic [WIDTH-1:0] alu;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic [15:0]      op_count;

  modport slave (
    input  valid_in, a, b, cin, ctl, ready_out,
    output ready_in, valid_out, alu, carry, zero, ovf, op_count
  );

  modport master (
    output valid_in, a, b, cin, ctl, ready_out,
    input  ready_in, valid_out, alu, carry, zero, ovf, op_count
  );

endinterface

// File: rtl/alu_out_fifo.sv
// Power-of-two result buffer; the producer guarantees it never pushes when full.
module alu_out_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(push) - CW'(do_pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage ALU (operand register, execute register) feeding a result FIFO with credit-style admission.
module alu_pipe_param
  import macro_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  alu_pipe_param_if.slave  bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OCC_W = CW + 1;
  localparam int RW    = WIDTH + 3;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  opcode_e          s1_ctl_q, s1_ctl_d;
  logic             s2_valid_q, s2_valid_d;
  logic [RW-1:0]    s2_res_q, s2_res_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             accept;
  logic [WIDTH-1:0] op2, res_alu;
  logic             ci, res_c, res_v, arith_ovf;
  logic [WIDTH:0]   sum;
  logic [RW-1:0]    fifo_dout;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [OCC_W-1:0] occupancy;

  // Admission counts results still in flight so the FIFO can never overflow.
  assign occupancy   = OCC_W'(fifo_count) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
  assign bus.ready_in = !reset && (occupancy < OCC_W'(DEPTH));
  assign accept       = bus.valid_in && bus.ready_in;

  // Every arithmetic op is one adder: a + op2 + ci.
  // NOTE: each always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op2 = '0;
    ci  = 1'b0;
    case (s1_ctl_q)
      OP_ADD:  op2 = s1_b_q;
      OP_ADDC: begin op2 = s1_b_q;  ci = s1_cin_q; end
      OP_SUB:  begin op2 = ~s1_b_q; ci = 1'b1;     end
      OP_SUBB: begin op2 = ~s1_b_q; ci = s1_cin_q; end
      OP_INC:  ci  = 1'b1;
      OP_DEC:  op2 = '1;
      default: ;
    endcase
    sum       = {1'b0, s1_a_q} + {1'b0, op2} + (WIDTH+1)'(ci);
    arith_ovf = (s1_a_q[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);

    res_alu = s1_a_q;
    res_c   = 1'b0;
    res_v   = 1'b0;
    case (s1_ctl_q)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBB, OP_INC, OP_DEC: begin
        res_alu = sum[WIDTH-1:0];
        res_c   = sum[WIDTH];
        res_v   = arith_ovf;
      end
      OP_AND:  res_alu = s1_a_q & s1_b_q;
      OP_OR:   res_alu = s1_a_q | s1_b_q;
      OP_XOR:  res_alu = s1_a_q ^ s1_b_q;
      OP_NOT:  res_alu = ~s1_a_q;
      OP_SHL:  begin res_alu = {s1_a_q[WIDTH-2:0], 1'b0};           res_c = s1_a_q[WIDTH-1]; end
      OP_SHR:  begin res_alu = {1'b0, s1_a_q[WIDTH-1:1]};           res_c = s1_a_q[0];       end
      OP_ROL:  begin res_alu = {s1_a_q[WIDTH-2:0], s1_a_q[WIDTH-1]}; res_c = s1_a_q[WIDTH-1]; end
      OP_ROR:  begin res_alu = {s1_a_q[0], s1_a_q[WIDTH-1:1]};       res_c = s1_a_q[0];       end
      OP_PASSB: res_alu = s1_b_q;
      default:  res_alu = s1_a_q;
    endcase
  end

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = accept ? bus.a   : s1_a_q;
    s1_b_d     = accept ? bus.b   : s1_b_q;
    s1_cin_d   = accept ? bus.cin : s1_cin_q;
    s1_ctl_d   = accept ? bus.ctl : s1_ctl_q;
    s2_valid_d = s1_valid_q;
    s2_res_d   = {res_v, (res_alu == '0), res_c, res_alu};
    op_count_d = op_count_q + 16'(accept);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_ctl_q   <= OP_ADD;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cin_q   <= s1_cin_d;
      s1_ctl_q   <= s1_ctl_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      op_count_q <= op_count_d;
    end
  end

  alu_out_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s2_valid_q),
    .din   (s2_res_q),
    .pop   (bus.ready_out),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read as zero whenever nothing is buffered, including during reset.
  assign bus.valid_out = !fifo_empty;
  assign {bus.ovf, bus.zero, bus.carry, bus.alu} = fifo_empty ? '0 : fifo_dout;
  assign bus.op_count  = op_count_q;

endmodule

// File: doc/alu_pipe_param.md
ALU_PIPE_PARAM -- requirements
Module: alu_pipe_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 SHALL have parameter DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  operation request.
REQ-006 SHALL have port ready_in  output  1  block accepts request this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; cin input 1 carry/borrow-in.
REQ-008 SHALL have port ctl  input  opcode_e  operation select.
REQ-009 SHALL have port valid_out  output  1  result available at buffer head.
REQ-010 SHALL have port ready_out  input  1  consumer takes result.
REQ-011 SHALL have ports alu output WIDTH result; carry, zero, ovf output 1 flags.
REQ-012 SHALL have port op_count  output  16  accepted-operation count, wraps 0xFFFF->0.

Function
REQ-013 SHALL accept a request on a clk edge where valid_in && ready_in; otherwise a, b, cin, ctl are ignored.
REQ-014 SHALL compute in a 2-stage pipeline (operand register, execute register), then push to a DEPTH-entry FIFO; unloaded latency accept-edge to valid_out = 2 cycles.
REQ-015 SHALL deassert ready_in when (FIFO occupancy + in-flight pipeline ops) >= DEPTH; pipeline never stalls, so no result is ever dropped.
REQ-016 SHALL pop the FIFO head on edges where valid_out && ready_out; push and pop in the same cycle leave occupancy unchanged.
REQ-017 SHALL hold alu/flags stable while valid_out=1 and ready_out=0.
REQ-018 SHALL implement: ADD a+b; ADDC a+b+cin; SUB a+~b+1; SUBB a+~b+cin; AND; OR; XOR; NOT ~a; SHL a<<1; SHR a>>1 logical; ROL; ROR; INC a+1; DEC a-1; PASSA; PASSB.
REQ-019 SHALL set carry = bit WIDTH of the WIDTH+1 sum for arithmetic (SUB: 1 = no borrow; DEC computed as a+all-ones, so DEC carry = 1 unless a=0); shifted-out bit for SHL/SHR/ROL/ROR; 0 for logic/pass.
REQ-020 SHALL set ovf = signed two's-complement overflow for ADD/ADDC/SUB/SUBB/INC/DEC, else 0.
REQ-021 SHALL set zero = (alu == 0) for every opcode.
REQ-022 SHALL increment op_count on each accepted request.
REQ-023 SHALL present undefined opcode encodings (none when 4-bit fully used) as PASSA.

Reset
REQ-024 SHALL, on reset assertion, immediately clear pipeline valids, FIFO pointers/occupancy, op_count; valid_out=0, alu=0, carry=0, zero=0, ovf=0.
REQ-025 SHALL drive ready_in=0 while reset is high and ready_in=1 on the first edge after release.
REQ-026 SHALL discard in-flight and buffered results on reset mid-operation; none appear after release.

Structure
REQ-027 SHALL keep opcode_e (4-bit: ADD 0, ADDC 1, SUB 2, SUBB 3, AND 4, OR 5, XOR 6, NOT 7, SHL 8, SHR 9, ROL 10, ROR 11, INC 12, DEC 13, PASSA 14, PASSB 15) and default WIDTH/DEPTH constants in macro_pkg.
REQ-028 SHALL instantiate one sub-module alu_out_fifo (parametrised width WIDTH+3, DEPTH) for the result buffer.

Verification
REQ-029 WIDTH=8: ADD a=0xFF b=0x01 -> after 2 cycles alu=0x00, carry=1, zero=1, ovf=0.
REQ-030 WIDTH=8: SUB a=0x80 b=0x01 -> alu=0x7F, carry=1, ovf=1, zero=0; SUBB a=0x00 b=0x00 cin=0 -> alu=0xFF, carry=0.
REQ-031 ready_out=0, DEPTH=4, valid_in held high -> exactly 4 accepts, ready_in=0 thereafter; release ready_out -> 4 results in issue order, no loss.
REQ-032 Continuous valid_in and ready_out=1 -> one result per cycle, ready_in constantly 1, op_count increments each cycle.
REQ-033 Reset asserted with 3 results buffered -> valid_out=0 same cycle, op_count=0, no stale results after release.
REQ-034 WIDTH=4: ROL a=0x9 -> alu=0x3, carry=1; SHR a=0x1 -> alu=0x0, carry=1, zero=1.
